// File: rtl/l2_line_responder.sv
// l2_line_responder: L2-side responder for the per-thread L1 instruction line buffers.
// Picks one pending line request at a time (branch > refill > sequential prefetch,
// round-robin inside the winning class), reads the 128-bit line from backing memory
// over a valid/ready port and broadcasts it with its thread ID and line address on a
// one-cycle response strobe that every L1 buffer snoops.
module l2_line_responder #(
    parameter int NTHREADS = 4,
    parameter int TIDW     = 2,
    parameter int LINE_W   = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NTHREADS-1:0]    req_refill,
    input  logic [NTHREADS-1:0]    br_req,
    input  logic [NTHREADS-1:0]    req_spec,
    input  logic [NTHREADS*32-1:0] req_addr,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [31:0]            mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [LINE_W-1:0]      mem_rsp_data,
    output logic                   rsp_valid,
    output logic [TIDW-1:0]        rsp_tid,
    output logic [31:0]            rsp_addr,
    output logic [LINE_W-1:0]      rsp_line,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Arbitration bookkeeping
    logic [TIDW-1:0]     rr_ptr;
    logic [NTHREADS-1:0] mask;

    // Latched transaction
    logic [TIDW-1:0]     tid_q;
    logic [31:0]         addr_q;

    // Request decode
    logic [31:0]         thread_addr [NTHREADS];
    logic [NTHREADS-1:0] elig_br;
    logic [NTHREADS-1:0] elig_refill;
    logic [NTHREADS-1:0] elig_spec;
    logic [NTHREADS-1:0] cand;
    logic                any_elig;
    logic                win_spec;
    logic                grant_found;
    logic [TIDW-1:0]     rr_idx;
    logic [TIDW-1:0]     grant_tid;
    logic [31:0]         grant_base;
    logic [31:0]         grant_addr;
    logic                unused_low_bits;

    // Split the packed address bus into one 32-bit address per thread.
    always_comb begin
        for (int t = 0; t < NTHREADS; t++) begin
            thread_addr[t] = req_addr[32*t +: 32];
        end
    end

    // Each thread competes only with its highest asserted class; the thread that was
    // just answered sits out one arbitration so its still-high level request is not
    // granted again before the L1 has had a chance to drop it.
    assign elig_br     = br_req & ~mask;
    assign elig_refill = req_refill & ~br_req & ~mask;
    assign elig_spec   = req_spec & ~req_refill & ~br_req & ~mask;
    assign any_elig    = |(elig_br | elig_refill | elig_spec);

    // Pick the highest class that has at least one eligible thread.
    always_comb begin
        cand     = elig_spec;
        win_spec = 1'b1;
        if (|elig_br) begin
            cand     = elig_br;
            win_spec = 1'b0;
        end else if (|elig_refill) begin
            cand     = elig_refill;
            win_spec = 1'b0;
        end
    end

    // Round-robin scan of the winning class starting at rr_ptr.
    always_comb begin
        grant_tid   = '0;
        grant_found = 1'b0;
        rr_idx      = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            rr_idx = rr_ptr + TIDW'(i);
            if (!grant_found && cand[rr_idx]) begin
                grant_tid   = rr_idx;
                grant_found = 1'b1;
            end
        end
    end

    // Demand and branch requests fetch their own line; a sequential prefetch fetches
    // the following line, wrapping from the top of the address space to zero.
    always_comb begin
        grant_base = thread_addr[grant_tid];
        if (win_spec) begin
            grant_addr = {grant_base[31:4] + 28'd1, 4'b0000};
        end else begin
            grant_addr = {grant_base[31:4], 4'b0000};
        end
    end

    assign unused_low_bits = ^grant_base[3:0];

    // FSM state register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: requests are only sampled in IDLE; a memory response is only
    // accepted in WAIT, so one arriving with the request handshake is not taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winning thread and line address and advance the round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tid_q  <= '0;
            addr_q <= '0;
            rr_ptr <= '0;
        end else if (state == IDLE && any_elig) begin
            tid_q  <= grant_tid;
            addr_q <= grant_addr;
            rr_ptr <= grant_tid + TIDW'(1);
        end
    end

    // Mask the thread being answered for the single arbitration that follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
        end else if (state == RESP) begin
            mask <= NTHREADS'(1) << tid_q;
        end else begin
            mask <= '0;
        end
    end

    // Registered response: strobe for one cycle, payload holds until the next response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_addr  <= '0;
            rsp_line  <= '0;
        end else if (state == WAIT && mem_rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_tid   <= tid_q;
            rsp_addr  <= addr_q;
            rsp_line  <= mem_rsp_data;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

    // Memory request port is driven straight from the latched address while in REQ.
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = (state == REQ) ? addr_q : 32'd0;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_l2_line_responder.sv
// Randomized scoreboard bench for l2_line_responder: a request-level model predicts the
// service order, a memory model answers reads, and a monitor compares every response.
module tb_l2_line_responder;

    localparam int NT   = 4;
    localparam int TIDW = 2;
    localparam int LW   = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic [NT-1:0]     req_refill;
    logic [NT-1:0]     br_req;
    logic [NT-1:0]     req_spec;
    logic [NT*32-1:0]  req_addr;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_req_addr;
    logic              mem_rsp_valid;
    logic [LW-1:0]     mem_rsp_data;
    logic              rsp_valid;
    logic [TIDW-1:0]   rsp_tid;
    logic [31:0]       rsp_addr;
    logic [LW-1:0]     rsp_line;
    logic              busy;

    always #5 clk = ~clk;

    l2_line_responder #(.NTHREADS(NT), .TIDW(TIDW), .LINE_W(LW)) dut (
        .clk(clk), .reset(reset),
        .req_refill(req_refill), .br_req(br_req), .req_spec(req_spec), .req_addr(req_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_addr(rsp_addr), .rsp_line(rsp_line),
        .busy(busy)
    );

    typedef struct packed {
        logic [TIDW-1:0] tid;
        logic [31:0]     addr;
    } exp_t;

    exp_t            exp_q[$];
    logic [TIDW-1:0] got_tid[$];
    logic [31:0]     got_addr[$];
    int              rsp_cycles[$];

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          ready_delay = 0;
    int          mem_lat = 1;
    int          model_rr = 0;
    int          rsp_count = 0;
    int          issue_cyc = 0;
    logic [31:0] salt = 32'h0;
    logic [2:0]  tbits [NT];   // per thread {br, refill, spec}
    logic [31:0] taddr [NT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Memory contents: a fixed scramble of the line address.
    function automatic logic [LW-1:0] line_of(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000 ^ salt, ~a, a + 32'h1357_9BDF, {a[15:0], a[31:16]} ^ salt};
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] a, input bit next_line);
        logic [31:0] base;
        base = a & 32'hFFFF_FFF0;
        return next_line ? base + 32'h10 : base;
    endfunction

    function automatic int class_of(input logic [2:0] b);
        return b[2] ? 3 : (b[1] ? 2 : (b[0] ? 1 : 0));
    endfunction

    // Backing memory: ready after ready_delay stalled cycles, data mem_lat cycles after handshake.
    initial begin : mem_model
        int          stall;
        int          pend;
        bit          waiting;
        logic [31:0] hs_addr;
        stall = 0; pend = 0; waiting = 1'b0; hs_addr = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (reset) begin
                mem_req_ready = 1'b0; stall = 0; waiting = 1'b0;
            end else begin
                if (mem_req_ready) begin
                    mem_req_ready = 1'b0;
                    pend = mem_lat;
                    waiting = 1'b0;
                end else if (waiting && !mem_req_valid) begin
                    tests_run++; tests_failed++;
                    $display("[TB] FAIL mem_req_valid_drop: got 0, expected 1 until accepted");
                    waiting = 1'b0; stall = 0;
                end
                if (mem_req_valid) begin
                    if (exp_q.size() > 0) begin
                        check_output("mem_req_addr", LW'(mem_req_addr), LW'(exp_q[0].addr));
                    end else begin
                        tests_run++; tests_failed++;
                        $display("[TB] FAIL unexpected_mem_req: got addr %0h, expected no request", mem_req_addr);
                    end
                    if (stall >= ready_delay) begin
                        mem_req_ready = 1'b1; hs_addr = mem_req_addr; stall = 0; waiting = 1'b0;
                    end else begin
                        stall++; waiting = 1'b1;
                    end
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = line_of(hs_addr);
                end
            end
        end
    end

    // Monitor: every response strobe is compared with the front of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_count++;
                rsp_cycles.push_back(cyc);
                got_tid.push_back(rsp_tid);
                got_addr.push_back(rsp_addr);
                if (exp_q.size() == 0) begin
                    tests_run++; tests_failed++;
                    $display("[TB] FAIL unexpected_rsp: got tid %0d addr %0h, expected no response", rsp_tid, rsp_addr);
                end else begin
                    e = exp_q.pop_front();
                    check_output("rsp_tid", LW'(rsp_tid), LW'(e.tid));
                    check_output("rsp_addr", LW'(rsp_addr), LW'(e.addr));
                    check_output("rsp_line", rsp_line, line_of(e.addr));
                end
            end
        end
    end

    // Reference model: serve requests one by one by class priority then round-robin.
    // In hold mode requests stay up, and the thread just served is skipped once if any
    // other thread is waiting.
    task automatic push_expected(input int grants, input bit remove, input bit mask_last);
        int   c [NT];
        int   ce [NT];
        int   best;
        int   t;
        int   last;
        bit   others;
        exp_t e;
        last = -1;
        for (int i = 0; i < NT; i++) c[i] = class_of(tbits[i]);
        for (int g = 0; g < grants; g++) begin
            for (int i = 0; i < NT; i++) ce[i] = c[i];
            if (mask_last && last >= 0) begin
                others = 1'b0;
                for (int i = 0; i < NT; i++) if (i != last && c[i] > 0) others = 1'b1;
                if (others) ce[last] = 0;
            end
            best = 0;
            for (int i = 0; i < NT; i++) if (ce[i] > best) best = ce[i];
            if (best == 0) break;
            t = 0;
            for (int k = 0; k < NT; k++) begin
                t = (model_rr + k) % NT;
                if (ce[t] == best) break;
            end
            e.tid  = TIDW'(t);
            e.addr = line_addr(taddr[t], best == 1);
            exp_q.push_back(e);
            model_rr = (t + 1) % NT;
            last = t;
            if (remove) c[t] = 0;
        end
    endtask

    task automatic drive_reqs();
        for (int t = 0; t < NT; t++) begin
            br_req[t]     = tbits[t][2];
            req_refill[t] = tbits[t][1];
            req_spec[t]   = tbits[t][0];
            req_addr[32*t +: 32] = taddr[t];
        end
    endtask

    task automatic clear_reqs();
        br_req = '0; req_refill = '0; req_spec = '0;
    endtask

    task automatic clear_table();
        for (int t = 0; t < NT; t++) begin
            tbits[t] = 3'b000; taddr[t] = 32'h0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        exp_q.delete();
        model_rr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Issue the request table in one cycle and predict its responses.
    task automatic apply_stimulus(input int hold_n);
        @(negedge clk);
        drive_reqs();
        issue_cyc = cyc;
        if (hold_n == 0) push_expected(NT, 1'b1, 1'b0);
        else             push_expected(hold_n, 1'b0, 1'b1);
    endtask

    // Act as the L1 buffers until the batch drains: a served thread drops its request,
    // or in hold mode everything drops after hold_n responses.
    task automatic run_until_done(input int hold_n);
        int budget;
        int seen;
        budget = 400; seen = 0;
        while (budget > 0) begin
            @(negedge clk);
            budget--;
            if (rsp_valid) begin
                seen++;
                if (hold_n == 0) begin
                    br_req[rsp_tid] = 1'b0; req_refill[rsp_tid] = 1'b0; req_spec[rsp_tid] = 1'b0;
                end else if (seen == hold_n) begin
                    clear_reqs();
                end
            end
            if (exp_q.size() == 0 && !busy && (br_req | req_refill | req_spec) == '0) break;
        end
        if (budget == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL batch_timeout: got %0d responses pending, expected 0", exp_q.size());
            reset_dut();
        end
        clear_reqs();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"}, LW'(busy), '0);
        check_output({tag, "_mem_req_valid"}, LW'(mem_req_valid), '0);
        check_output({tag, "_mem_req_addr"}, LW'(mem_req_addr), '0);
        check_output({tag, "_rsp_valid"}, LW'(rsp_valid), '0);
        check_output({tag, "_rsp_tid"}, LW'(rsp_tid), '0);
        check_output({tag, "_rsp_addr"}, LW'(rsp_addr), '0);
        check_output({tag, "_rsp_line"}, rsp_line, '0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int base;
        int snap;
        reset = 1'b1;
        clear_reqs();
        req_addr = '0;
        clear_table();
        @(negedge clk);
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single refill from thread 1 with the fastest memory: response three cycles later.
        ready_delay = 0; mem_lat = 1; salt = 32'h1234_5678;
        clear_table();
        tbits[1] = 3'b010; taddr[1] = 32'h0000_1238;
        base = got_addr.size();
        apply_stimulus(0);
        run_until_done(0);
        check_output("t1_addr", (got_addr.size() > base) ? LW'(got_addr[base]) : '1, LW'(32'h0000_1230));
        check_output("t1_latency", (rsp_cycles.size() > 0) ? LW'(rsp_cycles[rsp_cycles.size()-1] - issue_cyc) : '1, LW'(3));

        // Three classes at once: branch, then refill, then the prefetch of the next line.
        clear_table();
        tbits[0] = 3'b001; taddr[0] = 32'h0000_0040;
        tbits[2] = 3'b010; taddr[2] = 32'h0000_0080;
        tbits[3] = 3'b100; taddr[3] = 32'h0000_00C0;
        base = got_tid.size();
        apply_stimulus(0);
        run_until_done(0);
        check_output("t2_count", LW'(got_tid.size() - base), LW'(3));
        if (got_tid.size() >= base + 3) begin
            check_output("t2_first", LW'(got_tid[base]), LW'(3));
            check_output("t2_second", LW'(got_tid[base+1]), LW'(2));
            check_output("t2_third", LW'(got_tid[base+2]), LW'(0));
            check_output("t2_spec_addr", LW'(got_addr[base+2]), LW'(32'h0000_0050));
        end

        // All four threads hold refill requests: strict rotation from thread 0.
        reset_dut();
        clear_table();
        for (int t = 0; t < NT; t++) begin
            tbits[t] = 3'b010; taddr[t] = 32'h0000_0100 * (t + 1);
        end
        base = got_tid.size();
        apply_stimulus(5);
        run_until_done(5);
        check_output("t3_count", LW'(got_tid.size() - base), LW'(5));
        for (int k = 0; k < 5; k++) begin
            if (got_tid.size() > base + k) check_output($sformatf("t3_grant%0d", k), LW'(got_tid[base+k]), LW'(k % NT));
        end

        // A held branch request does not starve a held refill: the mask alternates them.
        clear_table();
        tbits[3] = 3'b100; taddr[3] = 32'h0000_0500;
        tbits[0] = 3'b010; taddr[0] = 32'h0000_0600;
        base = got_tid.size();
        apply_stimulus(4);
        run_until_done(4);
        for (int k = 0; k < 4; k++) begin
            if (got_tid.size() > base + k) check_output($sformatf("mask_grant%0d", k), LW'(got_tid[base+k]), LW'((k % 2 == 0) ? 3 : 0));
        end

        // A lone held request is re-served only after the masked cycle: one every 5 cycles.
        clear_table();
        tbits[2] = 3'b010; taddr[2] = 32'h0000_0700;
        base = rsp_cycles.size();
        apply_stimulus(3);
        run_until_done(3);
        check_output("hold_count", LW'(rsp_cycles.size() - base), LW'(3));
        for (int k = 1; k < 3; k++) begin
            if (rsp_cycles.size() > base + k) check_output($sformatf("hold_gap%0d", k), LW'(rsp_cycles[base+k] - rsp_cycles[base+k-1]), LW'(5));
        end

        // Sequential prefetch at the top of memory wraps to line 0.
        clear_table();
        tbits[2] = 3'b001; taddr[2] = 32'hFFFF_FFFC;
        base = got_addr.size();
        apply_stimulus(0);
        run_until_done(0);
        check_output("wrap_addr", (got_addr.size() > base) ? LW'(got_addr[base]) : '1, LW'(32'h0));

        // Memory holds off ready for 5 cycles: request stays put, exactly one response.
        ready_delay = 5; mem_lat = 2; salt = 32'h0BAD_F00D;
        clear_table();
        tbits[0] = 3'b010; taddr[0] = 32'h0000_2004;
        snap = rsp_count;
        apply_stimulus(0);
        run_until_done(0);
        repeat (4) @(negedge clk);
        check_output("stall_rsp_count", LW'(rsp_count - snap), LW'(1));

        // Reset while waiting for memory: outputs clear at once, the late data is dropped.
        ready_delay = 0; mem_lat = 6;
        clear_table();
        tbits[1] = 3'b010; taddr[1] = 32'h0000_3000;
        snap = rsp_count;
        apply_stimulus(0);
        begin
            int budget;
            budget = 20;
            while (budget > 0 && !mem_req_valid) begin
                @(negedge clk);
                budget--;
            end
            check_output("t6_reached_req", LW'(mem_req_valid), LW'(1));
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        clear_reqs();
        exp_q.delete();
        model_rr = 0;
        #1;
        check_all_zero("t6_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_output("t6_no_rsp", LW'(rsp_count - snap), LW'(0));
        check_output("t6_idle", LW'(busy), LW'(0));

        // Randomized batches, some with held requests.
        mem_lat = 1;
        for (int b = 0; b < 30; b++) begin
            int  n_hold;
            bit  any;
            ready_delay = $urandom_range(0, 3);
            mem_lat     = $urandom_range(1, 3);
            salt        = $urandom;
            any = 1'b0;
            for (int t = 0; t < NT; t++) begin
                tbits[t] = ($urandom_range(0, 2) != 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                taddr[t] = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
                if (tbits[t] != 3'b000) any = 1'b1;
            end
            if (!any) tbits[$urandom_range(0, NT-1)] = 3'b010;
            n_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 0;
            apply_stimulus(n_hold);
            run_until_done(n_hold);
        end

        check_output("final_scoreboard_empty", LW'(exp_q.size()), LW'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
